// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types, including the instruction-cache frame, address
// and controller-state definitions.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int ICACHE_SETS = 16;
  localparam int IIDX_W      = $clog2(ICACHE_SETS);
  localparam int ITAG_W      = 30 - IIDX_W;

  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    word_t             data;
  } icache_frame_t;

  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [1:0]        bytoff;
  } icache_addr_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_frames.sv
// Frame store for the direct-mapped instruction cache: one synchronous write
// port, one asynchronous read port, and a bulk valid clear.
module icache_frames
  import cpu_types_pkg::*;
#(
  parameter int SETS  = ICACHE_SETS,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic             clk,
  input  logic             clear_valid,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  word_t            wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output word_t            rd_data
);

  logic [SETS-1:0]  valid_r;
  logic [TAG_W-1:0] tag_r  [SETS];
  word_t            data_r [SETS];

  // Valid bits: a clear (flush or reset) takes priority over a fill.
  always_ff @(posedge clk) begin
    if (clear_valid) begin
      valid_r <= '0;
    end else if (we) begin
      valid_r[wr_idx] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Tag and data payload; left unreset because valid gates every use.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_r[wr_idx]  <= wr_tag;
      data_r[wr_idx] <= wr_data;
    end
  end

  // Asynchronous lookup port.
  always_comb begin
    rd_valid = valid_r[rd_idx];
    rd_tag   = tag_r[rd_idx];
    rd_data  = data_r[rd_idx];
  end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: same-cycle hits, single-word
// fills from the memory controller, saturating hit/miss counters.
module icache_direct
  import cpu_types_pkg::*;
#(
  parameter int SETS  = ICACHE_SETS,
  parameter int CNT_W = 16,
  localparam int IDX_W = $clog2(SETS),
  localparam int TAG_W = 30 - IDX_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  output logic [31:0]      imemload,
  output logic             ihit,
  input  logic             flush,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic             iwait,
  input  logic [31:0]      iload,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  icache_state_t    state_r;
  logic [29:0]      fetch_addr_r;
  logic [CNT_W-1:0] hit_count_r;
  logic [CNT_W-1:0] miss_count_r;

  logic [IDX_W-1:0] req_idx_s;
  logic [TAG_W-1:0] req_tag_s;
  logic             rd_valid_s;
  logic [TAG_W-1:0] rd_tag_s;
  word_t            rd_data_s;
  logic             fill_we_s;
  logic             unused_offset_s;

  assign req_idx_s       = imemaddr[IDX_W+1:2];
  assign req_tag_s       = imemaddr[31:IDX_W+2];
  assign unused_offset_s = ^imemaddr[1:0];

  // A fill is dropped when flush or reset lands on the same edge.
  assign fill_we_s = (state_r == FETCH) && !iwait && !flush && !RST;

  icache_frames #(
    .SETS  (SETS),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_frames (
    .clk         (CLK),
    .clear_valid (flush | RST),
    .we          (fill_we_s),
    .wr_idx      (fetch_addr_r[IDX_W-1:0]),
    .wr_tag      (fetch_addr_r[29:IDX_W]),
    .wr_data     (iload),
    .rd_idx      (req_idx_s),
    .rd_valid    (rd_valid_s),
    .rd_tag      (rd_tag_s),
    .rd_data     (rd_data_s)
  );

  // Datapath and memory-side outputs; reset and flush both mask a hit.
  always_comb begin
    ihit     = 1'b0;
    imemload = 32'h0000_0000;
    iREN     = 1'b0;
    iaddr    = 32'h0000_0000;
    if (RST) begin
      ihit = 1'b0;
    end else if (state_r == FETCH) begin
      iREN  = 1'b1;
      iaddr = {fetch_addr_r, 2'b00};
    end else begin
      ihit     = imemREN && rd_valid_s && (rd_tag_s == req_tag_s) && !flush;
      imemload = ihit ? rd_data_s : 32'h0000_0000;
    end
  end

  // Controller FSM plus saturating performance counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= IDLE;
      fetch_addr_r <= 30'd0;
      hit_count_r  <= {CNT_W{1'b0}};
      miss_count_r <= {CNT_W{1'b0}};
    end else begin
      if (ihit && (hit_count_r != {CNT_W{1'b1}})) begin
        hit_count_r <= hit_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      case (state_r)
        IDLE: begin
          if (imemREN && !ihit) begin
            fetch_addr_r <= imemaddr[31:2];
            state_r      <= FETCH;
            if (miss_count_r != {CNT_W{1'b1}}) begin
              miss_count_r <= miss_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end
        FETCH: begin
          if (flush || !iwait) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign hit_count  = hit_count_r;
  assign miss_count = miss_count_r;

endmodule

// File: tb/tb_icache_direct.sv
// Directed self-checking bench for icache_direct.
module tb_icache_direct;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] imemload;
  logic        ihit;
  logic        flush;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int tests = 0;
  int fails = 0;

  icache_direct dut (
    .CLK        (CLK),
    .RST        (RST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .imemload   (imemload),
    .ihit       (ihit),
    .flush      (flush),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1; imemREN = 1'b0; imemaddr = 32'h0; flush = 1'b0;
    iwait = 1'b1; iload = 32'h0;
    tick(); tick();
    check("rst_ihit", {31'd0, ihit}, 32'd0);
    check("rst_iren", {31'd0, iREN}, 32'd0);
    RST = 1'b0;
    #1;
    check("reset_iaddr", iaddr, 32'h0);
    check("reset_imemload", imemload, 32'h0);
    check("reset_hits", {16'd0, hit_count}, 32'd0);
    check("reset_miss", {16'd0, miss_count}, 32'd0);

    // 1: cold miss on 0x40 with three wait cycles
    imemREN = 1'b1; imemaddr = 32'h0000_0040; #1;
    check("t1_detect_ihit", {31'd0, ihit}, 32'd0);
    tick();
    check("t1_iren", {31'd0, iREN}, 32'd1);
    check("t1_iaddr", iaddr, 32'h40);
    check("t1_miss", {16'd0, miss_count}, 32'd1);
    tick(); tick();
    check("t1_iaddr_held", iaddr, 32'h40);
    check("t1_wait_ihit", {31'd0, ihit}, 32'd0);
    iwait = 1'b0; iload = 32'h8C22_0004;
    tick();
    check("t1_hit", {31'd0, ihit}, 32'd1);
    check("t1_data", imemload, 32'h8C22_0004);
    check("t1_iren_idle", {31'd0, iREN}, 32'd0);
    tick();
    check("t1_hits", {16'd0, hit_count}, 32'd1);
    check("t1_miss_after", {16'd0, miss_count}, 32'd1);

    // 2: offset bits ignored
    imemaddr = 32'h0000_0042; #1;
    check("t2_hit", {31'd0, ihit}, 32'd1);
    check("t2_data", imemload, 32'h8C22_0004);
    check("t2_iren", {31'd0, iREN}, 32'd0);
    tick();
    check("t2_hits", {16'd0, hit_count}, 32'd2);

    // 3: conflicting tag at index 0 evicts the frame
    imemaddr = 32'h0000_0440; iload = 32'hDEAD_BEEF; #1;
    check("t3_conflict_miss", {31'd0, ihit}, 32'd0);
    tick();
    check("t3_iaddr", iaddr, 32'h440);
    tick();
    check("t3_hit", {31'd0, ihit}, 32'd1);
    check("t3_data", imemload, 32'hDEAD_BEEF);
    imemaddr = 32'h0000_0040; #1;
    check("t3_reread_miss", {31'd0, ihit}, 32'd0);
    tick();
    check("t3_miss", {16'd0, miss_count}, 32'd3);
    check("t3_hits", {16'd0, hit_count}, 32'd2);
    iload = 32'h8C22_0004;
    tick();
    check("t3_refill_hit", {31'd0, ihit}, 32'd1);

    // 4: flush on the fill edge of a 0x80 fetch
    imemaddr = 32'h0000_0080; iwait = 1'b1;
    tick();
    check("t4_iaddr", iaddr, 32'h80);
    flush = 1'b1; iwait = 1'b0; iload = 32'h1111_1111; #1;
    check("t4_flush_ihit", {31'd0, ihit}, 32'd0);
    tick();
    flush = 1'b0; imemaddr = 32'h0000_0040; #1;
    check("t4_iren_dropped", {31'd0, iREN}, 32'd0);
    check("t4_reread_miss", {31'd0, ihit}, 32'd0);
    iwait = 1'b1;
    tick();
    check("t4_miss", {16'd0, miss_count}, 32'd5);

    // 5: reset in the middle of a fetch
    tick();
    RST = 1'b1; #1;
    check("t5_rst_iren", {31'd0, iREN}, 32'd0);
    check("t5_rst_ihit", {31'd0, ihit}, 32'd0);
    tick();
    RST = 1'b0; #1;
    check("t5_hits", {16'd0, hit_count}, 32'd0);
    check("t5_miss0", {16'd0, miss_count}, 32'd0);
    check("t5_iren", {31'd0, iREN}, 32'd0);
    check("t5_post_miss", {31'd0, ihit}, 32'd0);
    tick();
    check("t5_miss1", {16'd0, miss_count}, 32'd1);
    iwait = 1'b0; iload = 32'h8C22_0004;
    tick();
    check("t5_refill_hit", {31'd0, ihit}, 32'd1);

    // 6: hit counter saturation
    for (int i = 0; i < 65534; i++) tick();
    check("t6_fffe", {16'd0, hit_count}, 32'h0000_FFFE);
    tick();
    check("t6_ffff", {16'd0, hit_count}, 32'h0000_FFFF);
    tick();
    check("t6_sticky", {16'd0, hit_count}, 32'h0000_FFFF);
    imemaddr = 32'h0000_0080; #1;
    check("t6_80_not_filled", {31'd0, ihit}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
